// File: rtl/sd_dat_pkg.sv
// Shared definitions for the SD DAT0 block receiver.
//   - FSM state encoding
//   - Avalon register word offsets
//   - CTRL (write) and STATUS (read) bit positions
//   - CRC16-CCITT polynomial
//   - status flag struct and the STATUS word packer
package sd_dat_pkg;

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] WAIT_START = 3'd1;
  localparam logic [2:0] DATA       = 3'd2;
  localparam logic [2:0] CRC        = 3'd3;
  localparam logic [2:0] ENDB       = 3'd4;

  localparam logic [7:0] REG_CTRL    = 8'h80;
  localparam logic [7:0] REG_CLKDIV  = 8'h81;
  localparam logic [7:0] REG_TIMEOUT = 8'h82;

  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;
  localparam int CTRL_CLEAR = 2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_CRC_ERR = 2;
  localparam int STAT_TIMEOUT = 3;
  localparam int STAT_END_ERR = 4;

  localparam logic [15:0] CRC16_POLY = 16'h1021;

  typedef struct packed {
    logic end_err;
    logic timeout;
    logic crc_err;
    logic done;
  } flags_t;

  function automatic logic [31:0] pack_status(input logic busy, input flags_t f);
    logic [31:0] s;
    s               = '0;
    s[STAT_BUSY]    = busy;
    s[STAT_DONE]    = f.done;
    s[STAT_CRC_ERR] = f.crc_err;
    s[STAT_TIMEOUT] = f.timeout;
    s[STAT_END_ERR] = f.end_err;
    return s;
  endfunction

endpackage

// File: rtl/sd_dat_block_rx_if.sv
// Avalon-MM slave bus bundle for the SD DAT0 block receiver.
//   address    word address (0x00-0x7F buffer, 0x80 CTRL, 0x81 CLKDIV, 0x82 TIMEOUT)
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  write data
//   readdata   registered read data, one cycle after the read request
interface sd_dat_block_rx_if;
  logic [7:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/sd_crc16_serial.sv
// Bit-serial CRC16-CCITT (x^16+x^12+x^5+1), initial value 0, MSB-first.
// Only instantiated when SD_DAT_RX_CRC_EN is defined.
//   clk, reset_n  system clock, async active-low reset
//   clr_i         synchronous clear to 0 (wins over en_i)
//   en_i          shift one bit in
//   bit_i         data bit
//   crc_o         running CRC
module sd_crc16_serial
  import sd_dat_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic        bit_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q;
  logic        fb;

  assign fb    = crc_q[15] ^ bit_i;
  assign crc_o = crc_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      crc_q <= '0;
    end else if (clr_i) begin
      crc_q <= '0;
    end else if (en_i) begin
      crc_q <= {crc_q[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/sd_dat_block_rx.sv
// SD card DAT0 (1-bit mode) single-block receiver with Avalon-MM slave.
// Generates SD_CLK, hunts for the start bit, deserialises BLOCK_BYTES of data
// into a word buffer, takes the 16 CRC bits and the end bit, and reports status.
//   clk, reset_n  system clock, async active-low reset
//   bus           Avalon slave (sd_dat_block_rx_if.slave)
//   irq           high while done or timeout is set
//   sd_clk        SD card clock, low whenever the FSM is idle
//   sd_dat_in     DAT0 pad, asynchronous to clk
// Build option: SD_DAT_RX_CRC_EN enables the CRC16 check; without it the CRC
// bits are clocked through and crc_err always reads 0.
//
// state      | meaning
// IDLE       | sd_clk stopped, waiting for CTRL.start
// WAIT_START | sd_clk running, looking for the 0 start bit, timeout counting
// DATA       | shifting in 8*BLOCK_BYTES data bits, MSB of each byte first
// CRC        | shifting in the 16 CRC bits
// ENDB       | sampling the end bit, then setting done and going idle
module sd_dat_block_rx
  import sd_dat_pkg::*;
#(
  parameter int          BLOCK_BYTES     = 512,
  parameter logic [15:0] CLKDIV_DEFAULT  = 16'd63,
  parameter logic [15:0] TIMEOUT_DEFAULT = 16'hFFFF
) (
  input  logic                clk,
  input  logic                reset_n,
  sd_dat_block_rx_if.slave    bus,
  output logic                irq,
  output logic                sd_clk,
  input  logic                sd_dat_in
);

  localparam int          WORDS    = BLOCK_BYTES / 4;
  localparam int          AW       = $clog2(WORDS);
  localparam logic [12:0] LAST_BIT = 13'(8 * BLOCK_BYTES - 1);

  logic [2:0]  state_q, state_d;
  logic        dat_s1_q, dat_s2_q;
  logic [15:0] clkdiv_q, timeout_q;
  logic [15:0] div_cnt_q;
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        sd_clk_q;
  logic [12:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]  byte_q, byte_d;
  logic [31:0] word_q, word_d;
  flags_t      flags_q, flags_d;

  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram [WORDS];
  logic [31:0]   ram_rd_q;
  logic [31:0]   reg_rd_q;
  logic          sel_ram_q;

  logic bus_wr, bus_rd, ctrl_wr;
  logic abort_req, start_req, clr_req;
  logic running_q, running_d;
  logic sample;
  logic unused_wdata;

`ifdef SD_DAT_RX_CRC_EN
  logic [15:0] crc_rx_q, crc_rx_d;
  logic [15:0] crc_calc;
  logic        crc_clr, crc_en;

  sd_crc16_serial u_crc (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (crc_clr),
    .en_i    (crc_en),
    .bit_i   (dat_s2_q),
    .crc_o   (crc_calc)
  );
`endif

  assign bus_wr    = bus.chipselect && !bus.write_n;
  assign bus_rd    = bus.chipselect &&  bus.write_n;
  assign ctrl_wr   = bus_wr && (bus.address == REG_CTRL);
  assign abort_req = ctrl_wr && bus.writedata[CTRL_ABORT];
  // abort beats start in the same write; start is only honoured when idle
  assign start_req = ctrl_wr && bus.writedata[CTRL_START] && !bus.writedata[CTRL_ABORT]
                     && (state_q == IDLE);
  assign clr_req   = ctrl_wr && bus.writedata[CTRL_CLEAR];

  assign running_q = (state_q != IDLE);
  assign running_d = (state_d != IDLE);
  // a bit is taken on the clk that drives sd_clk high-to-low
  assign sample    = running_q && (div_cnt_q == 16'd0) && sd_clk_q && !abort_req;

  assign unused_wdata = ^bus.writedata[31:16];

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    byte_d    = byte_q;
    word_d    = word_q;
    tmo_cnt_d = tmo_cnt_q;
    flags_d   = flags_q;
    ram_we    = 1'b0;
    ram_waddr = bit_cnt_q[AW+4:5];
    ram_wdata = word_q;
`ifdef SD_DAT_RX_CRC_EN
    crc_rx_d  = crc_rx_q;
    crc_clr   = 1'b0;
    crc_en    = 1'b0;
`endif

    if (clr_req) flags_d = '0;

    case (state_q)
      IDLE: begin
        if (start_req) begin
          state_d   = WAIT_START;
          flags_d   = '0;
          bit_cnt_d = '0;
          tmo_cnt_d = timeout_q;
`ifdef SD_DAT_RX_CRC_EN
          crc_clr   = 1'b1;
`endif
        end
      end
      WAIT_START: begin
        if (sample) begin
          if (!dat_s2_q) begin
            state_d = DATA;
          end else if (tmo_cnt_q <= 16'd1) begin
            flags_d.timeout = 1'b1;
            state_d         = IDLE;
          end else begin
            tmo_cnt_d = tmo_cnt_q - 16'd1;
          end
        end
      end
      DATA: begin
        if (sample) begin
`ifdef SD_DAT_RX_CRC_EN
          crc_en = 1'b1;
`endif
          byte_d = {byte_q[6:0], dat_s2_q};
          if (bit_cnt_q[2:0] == 3'd7) word_d[{bit_cnt_q[4:3], 3'b000} +: 8] = byte_d;
          if (bit_cnt_q[4:0] == 5'd31) begin
            ram_we    = 1'b1;
            ram_wdata = word_d;
          end
          if (bit_cnt_q == LAST_BIT) begin
            state_d   = CRC;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 13'd1;
          end
        end
      end
      CRC: begin
        if (sample) begin
`ifdef SD_DAT_RX_CRC_EN
          crc_rx_d = {crc_rx_q[14:0], dat_s2_q};
`endif
          if (bit_cnt_q == 13'd15) begin
            state_d   = ENDB;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 13'd1;
          end
        end
      end
      ENDB: begin
        if (sample) begin
          flags_d.done    = 1'b1;
          flags_d.end_err = !dat_s2_q;
`ifdef SD_DAT_RX_CRC_EN
          flags_d.crc_err = (crc_rx_q != crc_calc);
`endif
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort_req) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      byte_q    <= '0;
      word_q    <= '0;
      tmo_cnt_q <= '0;
      flags_q   <= '0;
      dat_s1_q  <= 1'b1;
      dat_s2_q  <= 1'b1;
`ifdef SD_DAT_RX_CRC_EN
      crc_rx_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      byte_q    <= byte_d;
      word_q    <= word_d;
      tmo_cnt_q <= tmo_cnt_d;
      flags_q   <= flags_d;
      dat_s1_q  <= sd_dat_in;
      dat_s2_q  <= dat_s1_q;
`ifdef SD_DAT_RX_CRC_EN
      crc_rx_q  <= crc_rx_d;
`endif
    end
  end

  // SD_CLK phase timer; reloading from clkdiv_q at each boundary makes a new
  // CLKDIV apply from the next phase. Leaving or entering idle parks sd_clk low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sd_clk_q  <= 1'b0;
      div_cnt_q <= CLKDIV_DEFAULT;
    end else if (!running_q || !running_d) begin
      sd_clk_q  <= 1'b0;
      div_cnt_q <= clkdiv_q;
    end else if (div_cnt_q == 16'd0) begin
      sd_clk_q  <= ~sd_clk_q;
      div_cnt_q <= clkdiv_q;
    end else begin
      div_cnt_q <= div_cnt_q - 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clkdiv_q  <= CLKDIV_DEFAULT;
      timeout_q <= TIMEOUT_DEFAULT;
    end else if (bus_wr) begin
      if (bus.address == REG_CLKDIV)  clkdiv_q  <= bus.writedata[15:0];
      if (bus.address == REG_TIMEOUT) timeout_q <= bus.writedata[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
  end

  always_ff @(posedge clk) begin
    if (bus_rd) ram_rd_q <= ram[bus.address[AW-1:0]];
  end

  // register path is selected out of reset so readdata starts at 0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_ram_q <= 1'b0;
      reg_rd_q  <= '0;
    end else if (bus_rd) begin
      sel_ram_q <= !bus.address[7];
      case (bus.address)
        REG_CTRL:    reg_rd_q <= pack_status(running_q, flags_q);
        REG_CLKDIV:  reg_rd_q <= {16'h0000, clkdiv_q};
        REG_TIMEOUT: reg_rd_q <= {16'h0000, timeout_q};
        default:     reg_rd_q <= '0;
      endcase
    end
  end

  assign bus.readdata = sel_ram_q ? ram_rd_q : reg_rd_q;
  assign irq          = flags_q.done | flags_q.timeout;
  assign sd_clk       = sd_clk_q;

endmodule

// File: tb/tb_sd_dat_block_rx.sv
module tb_sd_dat_block_rx;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic irq, sd_clk;
  logic sd_dat_in = 1'b1;

  sd_dat_block_rx_if bus();

  sd_dat_block_rx dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .irq       (irq),
    .sd_clk    (sd_clk),
    .sd_dat_in (sd_dat_in)
  );

  always #5 clk = ~clk;

`ifdef SD_DAT_RX_CRC_EN
  localparam logic [31:0] EXP_BAD_CRC = 32'h06;
`else
  localparam logic [31:0] EXP_BAD_CRC = 32'h02;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  string       q_name[$];
  logic [31:0] q_exp[$];
  logic        rd_v = 1'b0;
  logic [7:0]  blk [512];
  logic [15:0] blk_crc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // read response monitor: one cycle after a read request, readdata is valid
  always @(posedge clk) rd_v <= bus.chipselect && bus.write_n;

  always @(negedge clk) begin
    if (rd_v) begin
      if (q_exp.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_read: got 0x%08h with empty scoreboard", bus.readdata);
      end else begin
        check(q_name.pop_front(), bus.readdata, q_exp.pop_front());
      end
    end
  end

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = a;
    bus.writedata  = d;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [7:0] a, input logic [31:0] exp, input string name);
    @(negedge clk);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    bus.address    = a;
    q_name.push_back(name);
    q_exp.push_back(exp);
    @(negedge clk);
    bus.chipselect = 1'b0;
  endtask

  task automatic set_pattern(input bit inv);
    for (int k = 0; k < 512; k++) blk[k] = inv ? 8'(255 - (k % 256)) : 8'(k % 256);
  endtask

  function automatic logic [15:0] crc_of_blk();
    logic [15:0] c;
    logic        fb;
    c = '0;
    for (int k = 0; k < 512; k++)
      for (int b = 7; b >= 0; b--) begin
        fb = c[15] ^ blk[k][b];
        c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
    return c;
  endfunction

  task automatic wait_fall(output bit ok);
    bit p;
    ok = 1'b0;
    p  = sd_clk;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (p && !sd_clk) begin
        ok = 1'b1;
        break;
      end
      p = sd_clk;
    end
  endtask

  // card model: new bit driven just after each host sampling edge
  task automatic card_send(input int n_bits, input int flip, input logic [15:0] crc, input bit endb);
    bit   ok;
    logic b;
    wait_fall(ok);
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL card_wait: no sd_clk fall before start bit");
      return;
    end
    sd_dat_in = 1'b0;
    for (int i = 0; i < n_bits; i++) begin
      wait_fall(ok);
      if (!ok) begin
        n_tests++; n_fail++;
        $display("FAIL card_wait: no sd_clk fall before data bit %0d", i);
        return;
      end
      b = blk[i / 8][7 - (i % 8)];
      if (i == flip) b = ~b;
      sd_dat_in = b;
    end
    if (n_bits < 4096) return;
    for (int j = 15; j >= 0; j--) begin
      wait_fall(ok);
      if (!ok) begin
        n_tests++; n_fail++;
        $display("FAIL card_wait: no sd_clk fall before crc bit %0d", j);
        return;
      end
      sd_dat_in = crc[j];
    end
    wait_fall(ok);
    sd_dat_in = endb;
    wait_fall(ok);
    sd_dat_in = 1'b1;
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL card_wait: no sd_clk fall for end bit");
    end
  endtask

  task automatic wait_irq();
    for (int i = 0; i < 50 && !irq; i++) @(negedge clk);
  endtask

  initial begin
    int hi;
    int falls;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = '0;
    bus.writedata  = '0;

    repeat (3) @(negedge clk);
    check("reset_readdata", bus.readdata, 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    check("reset_sd_clk", 32'(sd_clk), 32'h0);
    reset_n = 1'b1;

    // 1: reset register values, clock idle
    bus_read(8'h80, 32'h0, "t1_status");
    bus_read(8'h81, 32'd63, "t1_clkdiv");
    bus_read(8'h82, 32'hFFFF, "t1_timeout");
    hi = 0;
    repeat (20) begin
      @(negedge clk);
      if (sd_clk) hi++;
    end
    check("t1_sd_clk_idle", 32'(hi), 32'h0);

    // 2: good block
    bus_write(8'h81, 32'd1);
    set_pattern(1'b0);
    blk_crc = crc_of_blk();
    bus_write(8'h80, 32'h1);
    card_send(4096, -1, blk_crc, 1'b1);
    wait_irq();
    check("t2_irq", 32'(irq), 32'h1);
    bus_read(8'h80, 32'h02, "t2_status");
    bus_read(8'h00, 32'h03020100, "t2_word0");
    bus_read(8'h01, 32'h07060504, "t2_word1");
    bus_read(8'h40, 32'h03020100, "t2_word64");
    bus_read(8'h7F, 32'hFFFEFDFC, "t2_word127");

    // 3: one data bit flipped (MSB of byte 125)
    bus_write(8'h80, 32'h1);
    card_send(4096, 1000, blk_crc, 1'b1);
    wait_irq();
    bus_read(8'h80, EXP_BAD_CRC, "t3_status");
    bus_read(8'h1F, 32'h7F7EFD7C, "t3_word31");

    // 4: timeout after 10 SD_CLK cycles
    bus_write(8'h82, 32'd10);
    bus_write(8'h80, 32'h1);
    falls = 0;
    hi = 32'(sd_clk);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (hi != 0 && !sd_clk) falls++;
      hi = 32'(sd_clk);
      if (irq) break;
    end
    check("t4_sd_clk_cycles", 32'(falls), 32'd10);
    bus_read(8'h80, 32'h08, "t4_status");
    check("t4_irq_set", 32'(irq), 32'h1);
    bus_write(8'h80, 32'h4);
    bus_read(8'h80, 32'h00, "t4_status_cleared");
    check("t4_irq_cleared", 32'(irq), 32'h0);

    // start and abort together: abort wins
    bus_write(8'h80, 32'h3);
    bus_read(8'h80, 32'h00, "start_abort_same_cycle");

    // 5: abort mid-data, then a good block
    set_pattern(1'b1);
    bus_write(8'h80, 32'h1);
    card_send(101, -1, 16'h0, 1'b1);
    bus_write(8'h80, 32'h2);
    check("t5_sd_clk_after_abort", 32'(sd_clk), 32'h0);
    bus_read(8'h80, 32'h00, "t5_status_after_abort");
    check("t5_irq_after_abort", 32'(irq), 32'h0);
    sd_dat_in = 1'b1;
    bus_read(8'h00, 32'hFCFDFEFF, "t5_partial_word0");
    set_pattern(1'b0);
    blk_crc = crc_of_blk();
    bus_write(8'h80, 32'h1);
    card_send(4096, -1, blk_crc, 1'b1);
    wait_irq();
    bus_read(8'h80, 32'h02, "t5_status_restart");
    bus_read(8'h00, 32'h03020100, "t5_word0");
    bus_read(8'h7F, 32'hFFFEFDFC, "t5_word127");

    // 6: start while busy is ignored; bad end bit
    bus_write(8'h80, 32'h1);
    fork
      card_send(4096, -1, blk_crc, 1'b0);
      begin
        repeat (2000) @(posedge clk);
        bus_write(8'h80, 32'h1);
        bus_read(8'h80, 32'h01, "t6_busy_mid");
      end
    join
    wait_irq();
    bus_read(8'h80, 32'h12, "t6_status");
    check("t6_irq", 32'(irq), 32'h1);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(q_exp.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
